// File: rtl/wb_bus_arbiter.sv
// Two-master Wishbone arbiter. Master 0 (instruction cache) and master 1
// (data cache) share one external memory bus. A master keeps the bus for as
// long as it holds cyc, so line bursts are never split. Ties are resolved
// round-robin. A watchdog aborts a transfer the slave never acknowledges.
module wb_bus_arbiter #(
   parameter int RW   = 16,
   parameter int TO_W = 8
) (
   input  logic          i_clk,
   input  logic          i_rst,
   // master 0 (instruction cache)
   input  logic          m0_cyc,
   input  logic          m0_stb,
   input  logic          m0_we,
   input  logic [RW-1:0] m0_adr,
   input  logic [RW-1:0] m0_o_dat,
   input  logic [1:0]    m0_sel,
   output logic          m0_ack,
   output logic          m0_err,
   output logic [RW-1:0] m0_i_dat,
   // master 1 (data cache)
   input  logic          m1_cyc,
   input  logic          m1_stb,
   input  logic          m1_we,
   input  logic [RW-1:0] m1_adr,
   input  logic [RW-1:0] m1_o_dat,
   input  logic [1:0]    m1_sel,
   output logic          m1_ack,
   output logic          m1_err,
   output logic [RW-1:0] m1_i_dat,
   // shared slave bus
   output logic          wb_cyc,
   output logic          wb_stb,
   output logic          wb_we,
   output logic [RW-1:0] wb_adr,
   output logic [RW-1:0] wb_o_dat,
   output logic [1:0]    wb_sel,
   input  logic [RW-1:0] wb_i_dat,
   input  logic          wb_ack
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUS0 = 2'd1,
      S_BUS1 = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic              last_q, last_d;   // most recently granted master
   logic [TO_W-1:0]   wdt_q, wdt_d;     // stb-cycles since last ack or grant

   logic              bus0, bus1;
   logic              own_cyc, own_stb;
   logic              wdt_full;
   logic              expire;

   // Owner's request lines and the watchdog expiry condition.
   always_comb begin
      bus0     = (state_q == S_BUS0);
      bus1     = (state_q == S_BUS1);
      own_cyc  = (bus0 & m0_cyc) | (bus1 & m1_cyc);
      own_stb  = (bus0 & m0_stb) | (bus1 & m1_stb);
      wdt_full = &wdt_q;
      // A same-cycle ack beats expiry.
      expire   = (bus0 | bus1) & wdt_full & ~wb_ack;
   end

   // Next-state: round-robin grant from idle, burst lock while owned.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it
      // unassigned; otherwise synthesis infers a latch to hold the old value.
      state_d = state_q;
      last_d  = last_q;
      wdt_d   = wdt_q;
      case (state_q)
         S_IDLE: begin
            // Master 0 wins when alone, or on a tie when master 1 went last.
            if (m0_cyc && (!m1_cyc || last_q)) begin
               state_d = S_BUS0;
               last_d  = 1'b0;
               wdt_d   = '0;
            end else if (m1_cyc) begin
               state_d = S_BUS1;
               last_d  = 1'b1;
               wdt_d   = '0;
            end
         end
         S_BUS0, S_BUS1: begin
            if (!own_cyc || expire) begin
               state_d = S_IDLE;
            end
            if (wb_ack) begin
               wdt_d = '0;
            end else if (own_stb && !wdt_full) begin
               wdt_d = wdt_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers with asynchronous reset.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         last_q  <= 1'b1;
         wdt_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so all registers update together
         // from the values present before the edge.
         state_q <= state_d;
         last_q  <= last_d;
         wdt_q   <= wdt_d;
      end
   end

   // Bus routing from the current owner; everything is quiet when idle.
   always_comb begin
      wb_cyc   = 1'b0;
      wb_stb   = 1'b0;
      wb_we    = 1'b0;
      wb_adr   = '0;
      wb_o_dat = '0;
      wb_sel   = '0;
      m0_ack   = 1'b0;
      m0_err   = 1'b0;
      m1_ack   = 1'b0;
      m1_err   = 1'b0;
      m0_i_dat = wb_i_dat;
      m1_i_dat = wb_i_dat;
      if (bus0) begin
         wb_cyc   = m0_cyc;
         wb_stb   = m0_stb;
         wb_we    = m0_we;
         wb_adr   = m0_adr;
         wb_o_dat = m0_o_dat;
         wb_sel   = m0_sel;
         m0_ack   = wb_ack;
         m0_err   = expire;
      end else if (bus1) begin
         wb_cyc   = m1_cyc;
         wb_stb   = m1_stb;
         wb_we    = m1_we;
         wb_adr   = m1_adr;
         wb_o_dat = m1_o_dat;
         wb_sel   = m1_sel;
         m1_ack   = wb_ack;
         m1_err   = expire;
      end
   end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Self-checking bench for wb_bus_arbiter: a grant-sequence table, directed
// burst/timeout/reset sequences and a randomized run against an owner model.
module tb_wb_bus_arbiter;

   localparam int RW   = 16;
   localparam int TO_W = 3;
   localparam int MAXC = (1 << TO_W) - 1;

   logic          i_clk, i_rst;
   logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
   logic [RW-1:0] m0_adr, m0_o_dat, m1_adr, m1_o_dat;
   logic [1:0]    m0_sel, m1_sel;
   logic          m0_ack, m0_err, m1_ack, m1_err;
   logic [RW-1:0] m0_i_dat, m1_i_dat;
   logic          wb_cyc, wb_stb, wb_we, wb_ack;
   logic [RW-1:0] wb_adr, wb_o_dat, wb_i_dat;
   logic [1:0]    wb_sel;

   wb_bus_arbiter #(.RW(RW), .TO_W(TO_W)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
      .m0_o_dat(m0_o_dat), .m0_sel(m0_sel), .m0_ack(m0_ack), .m0_err(m0_err),
      .m0_i_dat(m0_i_dat),
      .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
      .m1_o_dat(m1_o_dat), .m1_sel(m1_sel), .m1_ack(m1_ack), .m1_err(m1_err),
      .m1_i_dat(m1_i_dat),
      .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
      .wb_o_dat(wb_o_dat), .wb_sel(wb_sel), .wb_i_dat(wb_i_dat), .wb_ack(wb_ack)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // owner: -1 = nobody, else index of the master holding the bus.
   // idle_cnt: stb-cycles without ack since the grant or the last ack.
   int owner    = -1;
   int last_m   = 1;
   int idle_cnt = 0;

   function automatic bit m_cyc(int m);
      return (m == 0) ? m0_cyc : m1_cyc;
   endfunction

   function automatic bit m_stb(int m);
      return (m == 0) ? m0_stb : m1_stb;
   endfunction

   function automatic bit model_expire();
      return (owner >= 0) && (idle_cnt == MAXC) && !wb_ack;
   endfunction

   function automatic logic [72:0] model_out();
      logic c, s, w, a0, e0, a1, e1;
      logic [RW-1:0] adr, dat;
      logic [1:0] sel;
      {c, s, w, a0, e0, a1, e1} = '0;
      adr = '0; dat = '0; sel = '0;
      if (owner == 0) begin
         {c, s, w, adr, dat, sel} = {m0_cyc, m0_stb, m0_we, m0_adr, m0_o_dat, m0_sel};
         a0 = wb_ack;
         e0 = model_expire();
      end else if (owner == 1) begin
         {c, s, w, adr, dat, sel} = {m1_cyc, m1_stb, m1_we, m1_adr, m1_o_dat, m1_sel};
         a1 = wb_ack;
         e1 = model_expire();
      end
      return {c, s, w, adr, dat, sel, a0, e0, a1, e1, wb_i_dat, wb_i_dat};
   endfunction

   function automatic void model_reset();
      owner = -1; last_m = 1; idle_cnt = 0;
   endfunction

   function automatic void model_step();
      bit ex;
      if (owner < 0) begin
         if (m0_cyc && m1_cyc) owner = 1 - last_m;
         else if (m0_cyc)      owner = 0;
         else if (m1_cyc)      owner = 1;
         if (owner >= 0) begin
            last_m   = owner;
            idle_cnt = 0;
         end
      end else begin
         ex = model_expire();
         if (wb_ack)              idle_cnt = 0;
         else if (m_stb(owner))   idle_cnt = (idle_cnt < MAXC) ? idle_cnt + 1 : MAXC;
         if (!m_cyc(owner) || ex) owner = -1;
      end
   endfunction

   wire [72:0] act_out = {wb_cyc, wb_stb, wb_we, wb_adr, wb_o_dat, wb_sel,
                          m0_ack, m0_err, m1_ack, m1_err, m0_i_dat, m1_i_dat};

   // Mid-cycle sample: compare every output against the model.
   task automatic settle(input string tag);
      @(negedge i_clk);
      check(tag, act_out, model_out());
   endtask

   // Advance one edge, keeping the model in step, then drive just after it.
   task automatic clock();
      @(posedge i_clk);
      if (i_rst) model_reset();
      else       model_step();
      #1;
   endtask

   task automatic all_idle();
      m0_cyc = 0; m0_stb = 0; m0_we = 0;
      m1_cyc = 0; m1_stb = 0; m1_we = 0;
      wb_ack = 0;
   endtask

   // ---------------- grant-sequence table ----------------
   typedef struct {
      logic          m0;
      logic          m1;
      logic          ack;
      logic          exp_cyc;
      logic [RW-1:0] exp_adr;
      logic          exp_a0;
      logic          exp_a1;
   } vec_t;

   vec_t tbl[17];

   initial begin
      // tie after reset -> m0, then m1 after one idle cycle
      tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0A00, 1'b1, 1'b0};
      tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0A00, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0B00, 1'b0, 1'b1};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0B00, 1'b0, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
      // m0 alone, then a tie goes to m1 first, m0 second
      tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
      tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0A00, 1'b0, 1'b0};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0A00, 1'b0, 1'b0};
      tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
      tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0B00, 1'b0, 1'b1};
      tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0B00, 1'b0, 1'b0};
      tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
      tbl[14] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h0A00, 1'b1, 1'b0};
      tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0A00, 1'b0, 1'b0};
      tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};

      // ---------- reset state ----------
      i_rst = 1;
      all_idle();
      m0_cyc = 1; m1_cyc = 1; wb_ack = 1;
      m0_adr = 16'h0A00; m1_adr = 16'h0B00;
      m0_o_dat = 16'hC0C0; m1_o_dat = 16'hD1D1;
      m0_sel = 2'b11; m1_sel = 2'b01;
      wb_i_dat = 16'h5A5A;
      #12;
      check("rst_wb_cyc", wb_cyc, 1'b0);
      check("rst_acks", {m0_ack, m1_ack, m0_err, m1_err}, 4'b0000);
      check("rst_idat", m0_i_dat, 16'h5A5A);
      all_idle();
      @(posedge i_clk); #1;
      i_rst = 0;
      model_reset();

      // ---------- table ----------
      for (int i = 0; i < 17; i++) begin
         m0_cyc = tbl[i].m0; m0_stb = tbl[i].m0;
         m1_cyc = tbl[i].m1; m1_stb = tbl[i].m1;
         wb_ack = tbl[i].ack;
         settle($sformatf("tbl%0d_model", i));
         check($sformatf("tbl%0d_cyc", i), wb_cyc, tbl[i].exp_cyc);
         check($sformatf("tbl%0d_adr", i), wb_adr, tbl[i].exp_adr);
         check($sformatf("tbl%0d_acks", i), {m0_ack, m1_ack}, {tbl[i].exp_a0, tbl[i].exp_a1});
         clock();
      end

      // ---------- single master 4-beat read ----------
      all_idle();
      m1_cyc = 1; m1_stb = 1; m1_adr = 16'h0200;
      settle("rd_req");
      check("rd_req_cyc", wb_cyc, 1'b0);
      clock();
      settle("rd_grant");
      check("rd_grant_cyc", wb_cyc, 1'b1);
      clock();
      for (int b = 0; b < 4; b++) begin
         logic [RW-1:0] d;
         d = 16'h1111 * (b + 1);
         m1_adr = 16'h0200 + 16'(b);
         wb_ack = 1; wb_i_dat = d;
         settle($sformatf("rd_beat%0d", b));
         check($sformatf("rd_beat%0d_ack", b), {m1_ack, m0_ack}, 2'b10);
         check($sformatf("rd_beat%0d_dat", b), m1_i_dat, d);
         clock();
      end
      all_idle();
      settle("rd_drop");
      clock();

      // ---------- burst lock ----------
      m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 16'h0100;
      m1_adr = 16'h0B00;
      settle("bl_req");
      clock();
      settle("bl_grant");
      check("bl_grant_adr", wb_adr, 16'h0100);
      clock();
      for (int b = 0; b < 4; b++) begin
         m0_adr = 16'h0100 + 16'(b);
         m0_o_dat = 16'hA000 + 16'(b);
         wb_ack = 1;
         if (b >= 1) begin m1_cyc = 1; m1_stb = 1; end
         settle($sformatf("bl_beat%0d", b));
         check($sformatf("bl_beat%0d_adr", b), wb_adr, 16'h0100 + 16'(b));
         check($sformatf("bl_beat%0d_ack", b), {m0_ack, m1_ack}, 2'b10);
         clock();
      end
      m0_cyc = 0; m0_stb = 0; m0_we = 0; wb_ack = 0;
      settle("bl_drop");
      check("bl_drop_cyc", wb_cyc, 1'b0);
      clock();
      settle("bl_gap");
      check("bl_gap_cyc", wb_cyc, 1'b0);
      clock();
      settle("bl_m1");
      check("bl_m1_adr", {wb_cyc, wb_adr}, {1'b1, 16'h0B00});
      clock();
      all_idle();
      settle("bl_end");
      clock();

      // ---------- timeout ----------
      m1_cyc = 1; m1_stb = 1;
      settle("to_req");
      clock();
      for (int k = 1; k <= MAXC + 1; k++) begin
         settle($sformatf("to_c%0d", k));
         check($sformatf("to_c%0d_err", k), {m1_err, m0_err}, {(k == MAXC + 1), 1'b0});
         clock();
      end
      m1_cyc = 0; m1_stb = 0;
      settle("to_after");
      check("to_after_cyc", wb_cyc, 1'b0);
      clock();

      // late ack on the expiry cycle suppresses err
      m1_cyc = 1; m1_stb = 1;
      settle("ta_req");
      clock();
      for (int k = 1; k <= MAXC + 1; k++) begin
         wb_ack = (k == MAXC + 1);
         settle($sformatf("ta_c%0d", k));
         check($sformatf("ta_c%0d_err", k), m1_err, 1'b0);
         clock();
      end
      wb_ack = 0;
      settle("ta_hold");
      check("ta_hold_cyc", {wb_cyc, m1_err}, 2'b10);
      clock();
      all_idle();
      settle("ta_end");
      clock();

      // ---------- async reset mid-burst ----------
      m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 16'h0300;
      settle("ar_req");
      clock();
      settle("ar_grant");
      clock();
      wb_ack = 1;
      settle("ar_beat1");
      clock();
      m0_adr = 16'h0301;
      settle("ar_beat2");
      #2 i_rst = 1;
      #1;
      check("ar_drop", {wb_cyc, wb_stb, m0_ack}, 3'b000);
      clock();
      i_rst = 0;
      all_idle();
      m0_cyc = 1; m1_cyc = 1; m0_adr = 16'h0A00; m1_adr = 16'h0B00;
      settle("ar_tie_req");
      clock();
      settle("ar_tie");
      check("ar_tie_owner", {wb_cyc, wb_adr}, {1'b1, 16'h0A00});
      clock();
      all_idle();
      settle("ar_end");
      clock();

      // ---------- randomized run ----------
      for (int n = 0; n < 3000; n++) begin
         if (m0_cyc) m0_cyc = ($urandom_range(5) != 0);
         else        m0_cyc = ($urandom_range(2) == 0);
         if (m1_cyc) m1_cyc = ($urandom_range(5) != 0);
         else        m1_cyc = ($urandom_range(2) == 0);
         m0_stb   = m0_cyc & ($urandom_range(7) != 0);
         m1_stb   = m1_cyc & ($urandom_range(7) != 0);
         m0_we    = 1'($urandom);
         m1_we    = 1'($urandom);
         m0_adr   = 16'($urandom);
         m1_adr   = 16'($urandom);
         m0_o_dat = 16'($urandom);
         m1_o_dat = 16'($urandom);
         m0_sel   = 2'($urandom);
         m1_sel   = 2'($urandom);
         wb_i_dat = 16'($urandom);
         wb_ack   = ($urandom_range(3) == 0);
         settle("rand");
         clock();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
